// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between vga_timing_gen and its consumer.
// master: the timing generator (drives syncs/counters/address, reads iColor).
// slave:  the pixel source / display side (drives iColor, observes the rest).
//   iColor          3-bit pixel colour for the current address
//   oHs/oVs         horizontal / vertical sync
//   oRGB            gated colour, zero during blanking
//   oDisplayEnable  high during active video
//   oColumn/oRow    current raster position
//   oColorAddress   linear frame-buffer address
//   oLineStart      one-pixel pulse at column 0
//   oFrameStart     one-pixel pulse at column 0, row 0
interface vga_timing_gen_if #(
   parameter int ADDR_W = 19
);
   logic [2:0]        iColor;
   logic              oHs;
   logic              oVs;
   logic [2:0]        oRGB;
   logic              oDisplayEnable;
   logic [15:0]       oColumn;
   logic [15:0]       oRow;
   logic [ADDR_W-1:0] oColorAddress;
   logic              oLineStart;
   logic              oFrameStart;

   modport master (
      input  iColor,
      output oHs, oVs, oRGB, oDisplayEnable, oColumn, oRow,
             oColorAddress, oLineStart, oFrameStart
   );

   modport slave (
      output iColor,
      input  oHs, oVs, oRGB, oDisplayEnable, oColumn, oRow,
             oColorAddress, oLineStart, oFrameStart
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, column/row counters, syncs, gated RGB, frame-buffer address.
// Latency: every output updates in the Clock cycle after the pixel-tick edge; all outputs mutually aligned.
// Backpressure: none; free-running raster, outputs held constant between pixel ticks.
// Ports:
//   Clock  single system clock, rising edge
//   Reset  synchronous, active-low
//   vga    vga_timing_gen_if.master (iColor in; syncs, enable, RGB, position, address, start pulses out)
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int ADDR_W   = 19
) (
   input  logic Clock,
   input  logic Reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);

   // column/row hold the position that the *next* tick will present on the
   // outputs; the registered oColumn/oRow trail them by one pixel.  This way
   // the first tick after reset presents row 0 / column 0.
   logic [4:0]  divCnt;
   logic [15:0] column;
   logic [15:0] row;

   logic pixTick;
   logic colWrap;
   logic rowWrap;
   logic hActive;
   logic vActive;
   logic hSync;
   logic vSync;
   logic frameOrigin;

   always_comb begin
      pixTick     = (divCnt == DIV_LAST);
      colWrap     = (column == H_LAST);
      rowWrap     = (row == V_LAST);
      hActive     = (column < H_ACT);
      vActive     = (row < V_ACT);
      hSync       = (column >= HS_BEG) && (column < HS_END);
      vSync       = (row >= VS_BEG) && (row < VS_END);
      frameOrigin = (column == 16'd0) && (row == 16'd0);
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         divCnt             <= '0;
         column             <= '0;
         row                <= '0;
         vga.oColumn        <= '0;
         vga.oRow           <= '0;
         vga.oHs            <= ~HS_POL;
         vga.oVs            <= ~VS_POL;
         vga.oDisplayEnable <= 1'b0;
         vga.oRGB           <= 3'b000;
         vga.oColorAddress  <= '0;
         vga.oLineStart     <= 1'b0;
         vga.oFrameStart    <= 1'b0;
      end else begin
         divCnt <= pixTick ? 5'd0 : divCnt + 5'd1;

         if (pixTick) begin
            column <= colWrap ? 16'd0 : column + 16'd1;
            if (colWrap) begin
               row <= rowWrap ? 16'd0 : row + 16'd1;
            end

            vga.oColumn        <= column;
            vga.oRow           <= row;
            vga.oHs            <= hSync ? HS_POL : ~HS_POL;
            // vSync only moves when row moves, which happens as column
            // returns to 0, so oVs can only change at column 0.
            vga.oVs            <= vSync ? VS_POL : ~VS_POL;
            vga.oDisplayEnable <= hActive && vActive;
            vga.oRGB           <= (hActive && vActive) ? vga.iColor : 3'b000;
            vga.oLineStart     <= (column == 16'd0);
            vga.oFrameStart    <= frameOrigin;

            // Incremental address: row*H_ACTIVE+column without a multiplier.
            // The last active pixel of a row is followed by blanking (held),
            // so the first pixel of the next row lands on the +1 value.
            if (frameOrigin) begin
               vga.oColorAddress <= '0;
            end else if (hActive && vActive) begin
               vga.oColorAddress <= vga.oColorAddress + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [2:0] color = 3'b101;
   int         passCnt = 0;
   int         totalCnt = 0;

   always #5 Clock = ~Clock;

   vga_timing_gen_if #(.ADDR_W(19)) ifDef ();
   vga_timing_gen_if #(.ADDR_W(8))  ifSml ();
   vga_timing_gen_if #(.ADDR_W(8))  ifTny ();
   vga_timing_gen_if #(.ADDR_W(8))  ifDv3 ();

   assign ifDef.iColor = color;
   assign ifSml.iColor = color;
   assign ifTny.iColor = color;
   assign ifDv3.iColor = color;

   // Full 640x480 defaults (only partial lines are simulated).
   vga_timing_gen uDef (.Clock(Clock), .Reset(Reset), .vga(ifDef));

   // Scaled frame: H_TOTAL=15, V_TOTAL=8, CLK_DIV=2 -> line 30, frame 240 cycles.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .ADDR_W(8)
   ) uSml (.Clock(Clock), .Reset(Reset), .vga(ifSml));

   // Positive-polarity tiny raster: H_TOTAL=7, V_TOTAL=6, CLK_DIV=1 -> 42 cycles.
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .ADDR_W(8)
   ) uTny (.Clock(Clock), .Reset(Reset), .vga(ifTny));

   // Divide-by-3: H_TOTAL=8, V_TOTAL=5 -> frame 120 cycles.
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .ADDR_W(8)
   ) uDv3 (.Clock(Clock), .Reset(Reset), .vga(ifDv3));

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      totalCnt++; if (ifDef.oHs !== 1'b1) $display("FAIL rst_hs: got %b expected 1", ifDef.oHs); else passCnt++;
      totalCnt++; if (ifDef.oVs !== 1'b1) $display("FAIL rst_vs: got %b expected 1", ifDef.oVs); else passCnt++;
      totalCnt++; if (ifDef.oDisplayEnable !== 1'b0) $display("FAIL rst_de: got %b expected 0", ifDef.oDisplayEnable); else passCnt++;
      totalCnt++; if (ifDef.oRGB !== 3'b000) $display("FAIL rst_rgb: got %b expected 000", ifDef.oRGB); else passCnt++;
      totalCnt++; if (ifDef.oColorAddress !== 19'd0) $display("FAIL rst_addr: got %0d expected 0", ifDef.oColorAddress); else passCnt++;
      totalCnt++; if ({ifDef.oLineStart, ifDef.oFrameStart} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {ifDef.oLineStart, ifDef.oFrameStart}); else passCnt++;
      totalCnt++; if ({ifDef.oColumn, ifDef.oRow} !== 32'd0) $display("FAIL rst_pos: got %h expected 0", {ifDef.oColumn, ifDef.oRow}); else passCnt++;
      totalCnt++; if ({ifTny.oHs, ifTny.oVs} !== 2'b00) $display("FAIL rst_pos_pol_syncs: got %b expected 00", {ifTny.oHs, ifTny.oVs}); else passCnt++;
      Reset = 1'b1;
      @(negedge Clock);
      // One edge after release: divide-by-2 has not ticked yet, divide-by-1 has.
      totalCnt++; if (ifDef.oFrameStart !== 1'b0) $display("FAIL rel_div2_early: got %b expected 0", ifDef.oFrameStart); else passCnt++;
      totalCnt++; if (ifTny.oFrameStart !== 1'b1) $display("FAIL rel_div1_fs: got %b expected 1", ifTny.oFrameStart); else passCnt++;
      @(negedge Clock);
      totalCnt++; if ({ifDef.oFrameStart, ifDef.oLineStart, ifDef.oDisplayEnable} !== 3'b111) $display("FAIL rel_first_pixel: got %b expected 111", {ifDef.oFrameStart, ifDef.oLineStart, ifDef.oDisplayEnable}); else passCnt++;
      totalCnt++; if (ifDef.oColorAddress !== 19'd0) $display("FAIL rel_addr: got %0d expected 0", ifDef.oColorAddress); else passCnt++;
   endtask

   task automatic test_default_line();
      int  firstLs = -1;
      int  secondLs = -1;
      int  hsLow = 0;
      bit  prevLs = 1'b0;
      int  a639 = -1;
      int  a700 = -1;
      int  a640 = -1;
      do_reset();
      for (int cyc = 0; cyc < 3400; cyc++) begin
         @(negedge Clock);
         if (ifDef.oLineStart && !prevLs) begin
            if (firstLs < 0) firstLs = cyc;
            else if (secondLs < 0) secondLs = cyc;
         end
         prevLs = ifDef.oLineStart;
         if (firstLs >= 0 && secondLs < 0 && ifDef.oHs == 1'b0) hsLow++;
         if (ifDef.oRow == 16'd0 && ifDef.oColumn == 16'd639) a639 = int'(ifDef.oColorAddress);
         if (ifDef.oRow == 16'd0 && ifDef.oColumn == 16'd700) a700 = int'(ifDef.oColorAddress);
         if (ifDef.oRow == 16'd1 && ifDef.oColumn == 16'd0)   a640 = int'(ifDef.oColorAddress);
      end
      totalCnt++; if (secondLs - firstLs !== 1600 || firstLs < 0) $display("FAIL def_line_period: got %0d expected 1600", secondLs - firstLs); else passCnt++;
      totalCnt++; if (hsLow !== 192) $display("FAIL def_hs_low: got %0d expected 192", hsLow); else passCnt++;
      totalCnt++; if (a639 !== 639) $display("FAIL def_addr_col639: got %0d expected 639", a639); else passCnt++;
      totalCnt++; if (a700 !== 639) $display("FAIL def_addr_hold: got %0d expected 639", a700); else passCnt++;
      totalCnt++; if (a640 !== 640) $display("FAIL def_addr_row1: got %0d expected 640", a640); else passCnt++;
   endtask

   task automatic test_small_frame();
      int  f1 = -1;
      int  f2 = -1;
      bit  prevFs = 1'b0;
      bit  prevVs = 1'b1;
      int  hsLow = 0;
      int  vsLow = 0;
      int  lsHigh = 0;
      int  fsHigh = 0;
      int  vsBadCol = 0;
      int  deBad = 0;
      int  rgbBad = 0;
      int  aLast = -1;
      int  aRow1 = -1;
      int  aNext = -1;
      logic expDe;
      color = 3'b101;
      do_reset();
      for (int cyc = 0; cyc < 560; cyc++) begin
         @(negedge Clock);
         if (ifSml.oFrameStart && !prevFs) begin
            if (f1 < 0) f1 = cyc;
            else if (f2 < 0) begin f2 = cyc; aNext = int'(ifSml.oColorAddress); end
         end
         prevFs = ifSml.oFrameStart;
         if (ifSml.oVs !== prevVs && ifSml.oColumn != 16'd0) vsBadCol++;
         prevVs = ifSml.oVs;
         expDe = (ifSml.oColumn < 16'd8) && (ifSml.oRow < 16'd4);
         if (f1 >= 0) begin
            if (ifSml.oDisplayEnable !== expDe) deBad++;
            if (ifSml.oRGB !== (expDe ? 3'b101 : 3'b000)) rgbBad++;
         end
         if (f1 >= 0 && f2 < 0) begin
            if (!ifSml.oHs) hsLow++;
            if (!ifSml.oVs) vsLow++;
            if (ifSml.oLineStart) lsHigh++;
            if (ifSml.oFrameStart) fsHigh++;
            if (ifSml.oRow == 16'd3 && ifSml.oColumn == 16'd7) aLast = int'(ifSml.oColorAddress);
            if (ifSml.oRow == 16'd1 && ifSml.oColumn == 16'd0) aRow1 = int'(ifSml.oColorAddress);
         end
      end
      totalCnt++; if (f2 - f1 !== 240 || f1 < 0) $display("FAIL sml_frame_period: got %0d expected 240", f2 - f1); else passCnt++;
      totalCnt++; if (hsLow !== 48) $display("FAIL sml_hs_low: got %0d expected 48", hsLow); else passCnt++;
      totalCnt++; if (vsLow !== 60) $display("FAIL sml_vs_low: got %0d expected 60", vsLow); else passCnt++;
      totalCnt++; if (lsHigh !== 16) $display("FAIL sml_ls_width: got %0d expected 16", lsHigh); else passCnt++;
      totalCnt++; if (fsHigh !== 2) $display("FAIL sml_fs_width: got %0d expected 2", fsHigh); else passCnt++;
      totalCnt++; if (vsBadCol !== 0) $display("FAIL sml_vs_at_col0: got %0d expected 0", vsBadCol); else passCnt++;
      totalCnt++; if (deBad !== 0) $display("FAIL sml_de: got %0d expected 0", deBad); else passCnt++;
      totalCnt++; if (rgbBad !== 0) $display("FAIL sml_rgb_gate: got %0d expected 0", rgbBad); else passCnt++;
      totalCnt++; if (aLast !== 31) $display("FAIL sml_addr_last: got %0d expected 31", aLast); else passCnt++;
      totalCnt++; if (aRow1 !== 8) $display("FAIL sml_addr_row1: got %0d expected 8", aRow1); else passCnt++;
      totalCnt++; if (aNext !== 0) $display("FAIL sml_addr_next_frame: got %0d expected 0", aNext); else passCnt++;
   endtask

   task automatic test_polarity_tiny();
      int  f1 = -1;
      int  f2 = -1;
      bit  prevFs = 1'b0;
      int  hsBad = 0;
      int  vsBad = 0;
      int  hsHigh = 0;
      int  vsHigh = 0;
      do_reset();
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge Clock);
         if (ifTny.oFrameStart && !prevFs) begin
            if (f1 < 0) f1 = cyc;
            else if (f2 < 0) f2 = cyc;
         end
         prevFs = ifTny.oFrameStart;
         if (f1 >= 0 && f2 < 0) begin
            if (ifTny.oHs !== (ifTny.oColumn == 16'd5)) hsBad++;
            if (ifTny.oVs !== (ifTny.oRow == 16'd4)) vsBad++;
            if (ifTny.oHs) hsHigh++;
            if (ifTny.oVs) vsHigh++;
         end
      end
      totalCnt++; if (f2 - f1 !== 42 || f1 < 0) $display("FAIL tny_frame_period: got %0d expected 42", f2 - f1); else passCnt++;
      totalCnt++; if (hsBad !== 0) $display("FAIL tny_hs_col5: got %0d expected 0", hsBad); else passCnt++;
      totalCnt++; if (vsBad !== 0) $display("FAIL tny_vs_row4: got %0d expected 0", vsBad); else passCnt++;
      totalCnt++; if (hsHigh !== 6) $display("FAIL tny_hs_count: got %0d expected 6", hsHigh); else passCnt++;
      totalCnt++; if (vsHigh !== 7) $display("FAIL tny_vs_count: got %0d expected 7", vsHigh); else passCnt++;
   endtask

   task automatic test_mid_reset();
      bit found = 1'b0;
      bit fsSeen = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 300 && !found; cyc++) begin
         @(negedge Clock);
         if (ifSml.oRow == 16'd2 && ifSml.oColumn == 16'd5) found = 1'b1;
      end
      totalCnt++; if (found !== 1'b1) $display("FAIL mid_reach_pos: got %b expected 1", found); else passCnt++;
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      totalCnt++; if ({ifSml.oColumn, ifSml.oRow} !== 32'd0) $display("FAIL mid_rst_pos: got %h expected 0", {ifSml.oColumn, ifSml.oRow}); else passCnt++;
      totalCnt++; if ({ifSml.oHs, ifSml.oVs, ifSml.oDisplayEnable, ifSml.oRGB, ifSml.oLineStart, ifSml.oFrameStart} !== 8'b11_0_000_00) $display("FAIL mid_rst_outs: got %b expected 11000000", {ifSml.oHs, ifSml.oVs, ifSml.oDisplayEnable, ifSml.oRGB, ifSml.oLineStart, ifSml.oFrameStart}); else passCnt++;
      totalCnt++; if (ifSml.oColorAddress !== 8'd0) $display("FAIL mid_rst_addr: got %0d expected 0", ifSml.oColorAddress); else passCnt++;
      Reset = 1'b1;
      for (int cyc = 0; cyc < 6 && !fsSeen; cyc++) begin
         @(negedge Clock);
         if (ifSml.oFrameStart) fsSeen = 1'b1;
      end
      totalCnt++; if (fsSeen !== 1'b1) $display("FAIL mid_rel_fs: got %b expected 1", fsSeen); else passCnt++;
      totalCnt++; if ({ifSml.oLineStart, ifSml.oDisplayEnable} !== 2'b11) $display("FAIL mid_rel_ls_de: got %b expected 11", {ifSml.oLineStart, ifSml.oDisplayEnable}); else passCnt++;
      totalCnt++; if (ifSml.oColorAddress !== 8'd0) $display("FAIL mid_rel_addr: got %0d expected 0", ifSml.oColorAddress); else passCnt++;
   endtask

   task automatic test_clkdiv3();
      logic [47:0] cur;
      logic [47:0] prevOut;
      int  lastChg = -100;
      int  viol = 0;
      int  pulses = 0;
      int  badW = 0;
      int  w = 0;
      int  f1 = -1;
      int  f2 = -1;
      bit  prevFs = 1'b0;
      do_reset();
      prevOut = {ifDv3.oHs, ifDv3.oVs, ifDv3.oRGB, ifDv3.oDisplayEnable, ifDv3.oColumn,
                 ifDv3.oRow, ifDv3.oColorAddress, ifDv3.oLineStart, ifDv3.oFrameStart};
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge Clock);
         cur = {ifDv3.oHs, ifDv3.oVs, ifDv3.oRGB, ifDv3.oDisplayEnable, ifDv3.oColumn,
                ifDv3.oRow, ifDv3.oColorAddress, ifDv3.oLineStart, ifDv3.oFrameStart};
         if (cur !== prevOut) begin
            if (cyc - lastChg < 3) viol++;
            lastChg = cyc;
         end
         prevOut = cur;
         if (ifDv3.oLineStart) w++;
         else if (w > 0) begin
            pulses++;
            if (w != 3) badW++;
            w = 0;
         end
         if (ifDv3.oFrameStart && !prevFs) begin
            if (f1 < 0) f1 = cyc;
            else if (f2 < 0) f2 = cyc;
         end
         prevFs = ifDv3.oFrameStart;
      end
      totalCnt++; if (viol !== 0) $display("FAIL dv3_stable: got %0d expected 0", viol); else passCnt++;
      totalCnt++; if (badW !== 0) $display("FAIL dv3_ls_width: got %0d expected 0", badW); else passCnt++;
      totalCnt++; if (pulses < 10) $display("FAIL dv3_ls_pulses: got %0d expected >=10", pulses); else passCnt++;
      totalCnt++; if (f2 - f1 !== 120 || f1 < 0) $display("FAIL dv3_frame_period: got %0d expected 120", f2 - f1); else passCnt++;
   endtask

   initial begin
      test_reset();
      test_default_line();
      test_small_frame();
      test_polarity_tiny();
      test_mid_reset();
      test_clkdiv3();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
